// File: rtl/jtframe_prog_packer_pkg.sv
// Shared constants for the ioctl-to-SDRAM programming path: byte-lane masks,
// writer states and the FIFO entry field widths ({addr, data16, mask2}).
package jtframe_prog_packer_pkg;

    localparam int DATA_BITS = 16;
    localparam int MASK_BITS = 2;

    // prog_mask is active-low per byte lane
    localparam logic [1:0] MASK_LO = 2'b10;
    localparam logic [1:0] MASK_HI = 2'b01;
    localparam logic [1:0] MASK_W  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } wr_state_t;

    function automatic logic [DATA_BITS-1:0] dup_byte(input logic [7:0] b);
        return {b, b};
    endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small first-word-fall-through FIFO. Push and pop may coincide at any fill
// level, including full, where the pop frees the slot the push reuses.
module jtframe_prog_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jtframe_prog_packer.sv
// Packs the ioctl ROM byte stream into 16-bit SDRAM programming writes.
// Optional header skipping is enabled with the JTFRAME_DWNLD_HEADER_EN macro.
module jtframe_prog_packer
    import jtframe_prog_packer_pkg::*;
#(
    parameter int AW      = 22,
    parameter int FIFO_AW = 3,
    parameter int HEADER  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic          ioctl_rom_wr,
    input  logic [26:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic [AW-1:0] prog_addr,
    output logic [15:0]   prog_data,
    output logic [1:0]    prog_mask,
    output logic          prog_we,
    input  logic          prog_rdy,
    output logic          dwnld_busy,
    output logic          ovf
);

    localparam int EW    = AW + DATA_BITS + MASK_BITS;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] WAIT_LVL = (FIFO_AW+1)'(DEPTH - 2);

    function automatic logic [EW-1:0] pack(input logic [AW-1:0] a,
                                           input logic [15:0] d,
                                           input logic [1:0] m);
        return {a, d, m};
    endfunction

    logic [26:0]    eff_addr;
    logic           hdr_skip;
    logic           unused_bits;

`ifdef JTFRAME_DWNLD_HEADER_EN
    assign eff_addr    = ioctl_addr - 27'(HEADER);
    assign hdr_skip    = ioctl_addr < 27'(HEADER);
    assign unused_bits = ^eff_addr[26:AW+1];
`else
    assign eff_addr    = ioctl_addr;
    assign hdr_skip    = 1'b0;
    assign unused_bits = ^{eff_addr[26:AW+1], 32'(HEADER)};
`endif

    logic [AW-1:0]  byte_word;
    logic           byte_odd;
    logic           strobe;
    logic           accept;
    logic           dl_q;
    logic           dl_rise;

    logic           hold_vld, hold_vld_n, hold_cur;
    logic [AW-1:0]  hold_addr, hold_addr_n;
    logic [7:0]     hold_lo, hold_lo_n;
    logic           pend_vld, pend_vld_n;
    logic [EW-1:0]  pend_ent, pend_ent_n;
    logic           push;
    logic [EW-1:0]  push_ent;

    logic           pop;
    logic [EW-1:0]  head;
    logic [FIFO_AW:0] fifo_count, count_nxt;
    logic           fifo_empty, fifo_full;
    logic           push_ok, pop_ok;

    wr_state_t      st, st_nxt;

    assign byte_word = eff_addr[AW:1];
    assign byte_odd  = eff_addr[0];
    assign strobe    = downloading & ioctl_rom_wr;
    assign accept    = strobe & ~fifo_full & ~hdr_skip;
    assign dl_rise   = downloading & ~dl_q;
    assign hold_cur  = hold_vld & ~dl_rise;

    // Packer: a stray odd byte that cannot push this cycle waits in pend
    always_comb begin
        hold_vld_n  = hold_cur;
        hold_addr_n = hold_addr;
        hold_lo_n   = hold_lo;
        pend_vld_n  = 1'b0;
        pend_ent_n  = pend_ent;
        push        = pend_vld;
        push_ent    = pend_ent;
        if (accept) begin
            if (hold_cur) begin
                push = 1'b1;
                if (byte_odd && byte_word == hold_addr) begin
                    push_ent   = pack(hold_addr, {ioctl_dout, hold_lo}, MASK_W);
                    hold_vld_n = 1'b0;
                end else begin
                    push_ent = pack(hold_addr, dup_byte(hold_lo), MASK_LO);
                    if (byte_odd) begin
                        hold_vld_n = 1'b0;
                        pend_vld_n = 1'b1;
                        pend_ent_n = pack(byte_word, dup_byte(ioctl_dout), MASK_HI);
                    end else begin
                        hold_addr_n = byte_word;
                        hold_lo_n   = ioctl_dout;
                    end
                end
            end else if (!byte_odd) begin
                hold_vld_n  = 1'b1;
                hold_addr_n = byte_word;
                hold_lo_n   = ioctl_dout;
            end else if (pend_vld) begin
                pend_vld_n = 1'b1;
                pend_ent_n = pack(byte_word, dup_byte(ioctl_dout), MASK_HI);
            end else begin
                push     = 1'b1;
                push_ent = pack(byte_word, dup_byte(ioctl_dout), MASK_HI);
            end
        end else if (!downloading && hold_cur && !pend_vld) begin
            push       = 1'b1;
            push_ent   = pack(hold_addr, dup_byte(hold_lo), MASK_LO);
            hold_vld_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q      <= 1'b0;
            hold_vld  <= 1'b0;
            hold_addr <= '0;
            hold_lo   <= '0;
            pend_vld  <= 1'b0;
            pend_ent  <= '0;
            ovf       <= 1'b0;
        end else begin
            dl_q      <= downloading;
            hold_vld  <= hold_vld_n;
            hold_addr <= hold_addr_n;
            hold_lo   <= hold_lo_n;
            pend_vld  <= pend_vld_n;
            pend_ent  <= pend_ent_n;
            if (dl_rise)
                ovf <= 1'b0;
            else if (strobe && fifo_full && !hdr_skip)
                ovf <= 1'b1;
        end
    end

    jtframe_prog_fifo #(
        .DW (EW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_ent),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign pop_ok    = pop & ~fifo_empty;
    assign push_ok   = push & (~fifo_full | pop_ok);
    assign count_nxt = fifo_count + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop_ok);

    // Writer FSM: head is only popped once the SDRAM acknowledges it
    always_comb begin
        st_nxt = st;
        pop    = 1'b0;
        case (st)
            ST_IDLE: if (!fifo_empty) st_nxt = ST_REQ;
            ST_REQ:  if (prog_rdy) begin
                         pop    = 1'b1;
                         st_nxt = ST_GAP;
                     end
            ST_GAP:  st_nxt = ST_IDLE;
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_addr  <= '0;
            prog_data  <= '0;
            prog_mask  <= '0;
            prog_we    <= 1'b0;
            ioctl_wait <= 1'b0;
            dwnld_busy <= 1'b0;
        end else begin
            if (st == ST_IDLE && !fifo_empty) begin
                {prog_addr, prog_data, prog_mask} <= head;
                prog_we <= 1'b1;
            end else if (st == ST_REQ && prog_rdy) begin
                prog_we <= 1'b0;
            end
            ioctl_wait <= count_nxt >= WAIT_LVL;
            dwnld_busy <= downloading | hold_vld_n | pend_vld_n |
                          (count_nxt != '0) | (st_nxt != ST_IDLE);
        end
    end

endmodule
